// File: rtl/cmp_sweep_pkg.sv
// Shared state encoding and width helpers for the compare/select sweep checker.
package cmp_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Vector index width: {select, a, b}
    function automatic int unsigned vec_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

    // Error counter width: holds the full vector count without wrapping
    function automatic int unsigned err_w(input int unsigned width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/cmp_golden.sv
// Golden model of the compare/select datapath: select=0 -> a<b, select=1 -> a>b (unsigned).
module cmp_golden #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    output logic             expected_c
);

    // Pure combinational reference result
    assign expected_c = select ? (a > b) : (a < b);

endmodule

// File: rtl/cmp_sweep_checker.sv
// Exhaustive {select, a, b} sweep driver and checker for the compare/select datapath.
// Optional macro CMP_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module cmp_sweep_checker
    import cmp_sweep_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [WIDTH-1:0]       out_a,
    output logic [WIDTH-1:0]       out_b,
    output logic                   out_select,
    input  logic                   in_s,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH+1:0]     out_errors,
    output logic [2*WIDTH:0]       out_fail_idx,
    output logic                   out_fail_valid
);

    localparam int unsigned VEC_W = vec_w(WIDTH);
    localparam int unsigned ERR_W = err_w(WIDTH);
    localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [VEC_W-1:0] LAST_IDX  = '1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_d, b_d;
    logic               select_d;
    logic               busy_d, done_d;
    logic [ERR_W-1:0]   errors_d;
    logic [VEC_W-1:0]   fail_idx_d;
    logic               fail_valid_d;
    logic               expected_c;
    logic               mismatch_c;

    cmp_golden #(.WIDTH(WIDTH)) u_golden (
        .a          (out_a),
        .b          (out_b),
        .select     (out_select),
        .expected_c (expected_c)
    );

    assign mismatch_c = (in_s != expected_c);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_DRIVE;
            S_DRIVE: state_d = (SETTLE > 0) ? S_WAIT : S_CHECK;
            S_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = S_CHECK;
            S_CHECK: begin
                if (idx_q == LAST_IDX) state_d = S_DONE;
`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
                else if (mismatch_c)   state_d = S_DONE;
`endif
                else                   state_d = S_DRIVE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the registered datapath and status outputs
    always_comb begin
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        a_d          = out_a;
        b_d          = out_b;
        select_d     = out_select;
        errors_d     = out_errors;
        fail_idx_d   = out_fail_idx;
        fail_valid_d = out_fail_valid;
        busy_d       = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d       = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    errors_d     = '0;
                    fail_idx_d   = '0;
                    fail_valid_d = 1'b0;
                    idx_d        = '0;
                end
            end
            S_DRIVE: begin
                {select_d, a_d, b_d} = idx_q;
                cnt_d                = SETTLE_LD;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_CHECK: begin
                if (mismatch_c) begin
                    errors_d = out_errors + ERR_W'(1);
                    if (!out_fail_valid) begin
                        fail_valid_d = 1'b1;
                        fail_idx_d   = idx_q;
                    end
                end
                if (state_d == S_DRIVE) idx_d = idx_q + VEC_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            cnt_q          <= '0;
            out_a          <= '0;
            out_b          <= '0;
            out_select     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            out_errors     <= '0;
            out_fail_idx   <= '0;
            out_fail_valid <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            out_a          <= a_d;
            out_b          <= b_d;
            out_select     <= select_d;
            busy           <= busy_d;
            done           <= done_d;
            out_errors     <= errors_d;
            out_fail_idx   <= fail_idx_d;
            out_fail_valid <= fail_valid_d;
        end
    end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Self-checking bench for cmp_sweep_checker: SETTLE=1 and SETTLE=0 instances driving a modelled datapath.
module tb_cmp_sweep_checker;

    localparam int W = 2;
    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start0;
    logic [1:0] a1, b1, a0, b0;
    logic       sel1, sel0, s1, s0;
    logic       busy1, busy0, done1, done0;
    logic [5:0] err1, err0;
    logic [4:0] fidx1, fidx0;
    logic       fv1, fv0;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 random flip table
    int dsel   = 1;   // 1 -> SETTLE=1 instance, 0 -> SETTLE=0 instance
    bit flip [0:N-1];

    cmp_sweep_checker #(.WIDTH(W), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .out_a(a1), .out_b(b1), .out_select(sel1), .in_s(s1),
        .busy(busy1), .done(done1), .out_errors(err1),
        .out_fail_idx(fidx1), .out_fail_valid(fv1)
    );

    cmp_sweep_checker #(.WIDTH(W), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .out_a(a0), .out_b(b0), .out_select(sel0), .in_s(s0),
        .busy(busy0), .done(done0), .out_errors(err0),
        .out_fail_idx(fidx0), .out_fail_valid(fv0)
    );

    function automatic bit golden(input int sel, input int a, input int b);
        return (sel != 0) ? (a > b) : (a < b);
    endfunction

    // Behavioural datapath under test, with injected faults
    always_comb begin
        case (mode)
            0:       s1 = golden(int'(sel1), int'(a1), int'(b1));
            1:       s1 = 1'b0;
            2:       s1 = 1'b1;
            default: s1 = golden(int'(sel1), int'(a1), int'(b1)) ^ flip[{sel1, a1, b1}];
        endcase
        case (mode)
            0:       s0 = golden(int'(sel0), int'(a0), int'(b0));
            1:       s0 = 1'b0;
            2:       s0 = 1'b1;
            default: s0 = golden(int'(sel0), int'(a0), int'(b0)) ^ flip[{sel0, a0, b0}];
        endcase
    end

    function automatic bit dut_resp(input int m, input int sel, input int a, input int b);
        case (m)
            0:       return golden(sel, a, b);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return golden(sel, a, b) ^ flip[sel * 16 + a * 4 + b];
        endcase
    endfunction

    logic       o_done, o_busy, o_sel, o_fv;
    logic [1:0] o_a, o_b;
    logic [5:0] o_err;
    logic [4:0] o_fidx;
    always_comb begin
        o_done = (dsel != 0) ? done1 : done0;
        o_busy = (dsel != 0) ? busy1 : busy0;
        o_sel  = (dsel != 0) ? sel1  : sel0;
        o_a    = (dsel != 0) ? a1    : a0;
        o_b    = (dsel != 0) ? b1    : b0;
        o_err  = (dsel != 0) ? err1  : err0;
        o_fidx = (dsel != 0) ? fidx1 : fidx0;
        o_fv   = (dsel != 0) ? fv1   : fv0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (dsel != 0) start1 = v;
        else           start0 = v;
    endtask

    // Pulse start, then watch done for a bounded window; optional extra start pulse at extra_at
    task automatic run_sweep(input int extra_at, output int done_cyc, output int ndone);
        int s     = (dsel != 0) ? 1 : 0;
        int limit = N * (s + 2) + 40;
        done_cyc = -1;
        ndone    = 0;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (cyc == extra_at) set_start(1'b1);
            @(posedge clk);
            #1;
            if (cyc == extra_at) set_start(1'b0);
            if (cyc == 1) chk("busy_after_start", 32'(o_busy), 32'd1);
            if (o_done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    endtask

    // Reference: walk the vector space by the sweep rules and compare with the observed results
    task automatic check_sweep(input string tag, input int extra_at);
        int s = (dsel != 0) ? 1 : 0;
        int errs = 0, first = 0, run = N, last;
        bit fv = 0;
        int dc, nd;
        for (int i = 0; i < N; i++) begin
            if (dut_resp(mode, i / 16, (i / 4) % 4, i % 4) != golden(i / 16, (i / 4) % 4, i % 4)) begin
                errs++;
                if (!fv) begin
                    fv    = 1'b1;
                    first = i;
`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
                    run   = i + 1;
                    break;
`endif
                end
            end
        end
        last = run - 1;
        run_sweep(extra_at, dc, nd);
        chk({tag, "_done_cycle"}, 32'(dc), 32'(run * (s + 2)));
        chk({tag, "_done_count"}, 32'(nd), 32'd1);
        chk({tag, "_errors"},     32'(o_err), 32'(errs));
        chk({tag, "_fail_valid"}, 32'(o_fv), 32'(fv));
        chk({tag, "_fail_idx"},   32'(o_fidx), 32'(first));
        chk({tag, "_hold_sel"},   32'(o_sel), 32'(last / 16));
        chk({tag, "_hold_a"},     32'(o_a), 32'((last / 4) % 4));
        chk({tag, "_hold_b"},     32'(o_b), 32'(last % 4));
        chk({tag, "_idle_busy"},  32'(o_busy), 32'd0);
    endtask

    initial begin
        int d1, d2, nd;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_outs", 32'({err1, fidx1, fv1, sel1, a1, b1}), 32'd0);
        chk("rst_outs0", 32'({err0, fidx0, fv0, sel0, a0, b0, busy0, done0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sweeps on the SETTLE=1 instance
        dsel = 1;
        mode = 0; check_sweep("s1_correct", 0);
        mode = 1; check_sweep("s1_stuck0", 0);
        mode = 2; check_sweep("s1_stuck1", 0);

        // SETTLE=0 instance, with a start pulse while busy
        dsel = 0;
        mode = 0; check_sweep("s0_correct_restart", 20);

        // Asynchronous reset mid-sweep
        dsel = 1;
        mode = 2;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_done", 32'(done1), 32'd0);
        chk("midrst_outs", 32'({err1, fidx1, fv1, sel1, a1, b1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk);
            #1 if (done1 === 1'b1) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        mode = 0; check_sweep("s1_after_reset", 0);

        // Start held high: a second sweep follows from IDLE
        dsel = 1;
        mode = 0;
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        start1 = 1'b1;
        for (int cyc = 0; cyc < 260; cyc++) begin
            @(posedge clk);
            #1;
            if (done1 === 1'b1) begin
                if (d1 < 0)      d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
        end
        start1 = 1'b0;
        chk("held_start_gap", 32'(d2 - d1), 32'(N * 3 + 2));
        repeat (120) @(posedge clk);

        // Randomized fault tables on both instances
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 3) == 0);
            mode = 3;
            dsel = r % 2;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            check_sweep($sformatf("rand%0d", r), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
